// File: rtl/adder8_mp_seq_if.sv
// adder8_mp_seq_if: bundle of the sequencer's request/response handshake and
// its byte-wide link to the shared 8-bit adder (adder8_44).
//   slave  : the sequencer's view. It takes the request and the adder results,
//            and drives the response and the adder operands.
//   master : the environment's view. This is the requesting control unit
//            together with the external adder.
// Request : start, op_sub, a_in[W], b_in[W], cin
// Response: busy, done, sum_out[W], cout_out, ovf_out
// Adder   : add_a[8], add_b[8], add_cin -> adder; add_sum[8], add_cout <- adder
interface adder8_mp_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic         op_sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;

    modport slave (
        input  start, op_sub, a_in, b_in, cin, add_sum, add_cout,
        output busy, done, sum_out, cout_out, ovf_out, add_a, add_b, add_cin
    );

    modport master (
        output start, op_sub, a_in, b_in, cin, add_sum, add_cout,
        input  busy, done, sum_out, cout_out, ovf_out, add_a, add_b, add_cin
    );
endinterface

// File: rtl/adder8_mp_seq.sv
// adder8_mp_seq: multi-precision add/subtract sequencer.
// It time-multiplexes one external 8-bit adder over NBYTES-wide operands. The
// sequencer issues one byte per clock, starting with the LSB, and chains the
// carry from byte to byte.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : adder8_mp_seq_if.slave. It carries the start/done request, the
//             operands and results, and the adder byte link. The NBYTES value
//             of the interface instance must match this module's NBYTES.
// Sequence: IDLE -(start)-> RUN (NBYTES cycles, one byte each) -> DONE -> IDLE.
// done is high in the cycle after the edge that captures the last byte.
module adder8_mp_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    adder8_mp_seq_if.slave      bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           sub_q, sub_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic [7:0]     add_a_c;
    logic [7:0]     add_b_c;
    logic           add_cin_c;
    logic           last_byte;

    assign last_byte = (idx_q == IW'(NBYTES - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        add_a_c   = 8'h00;
        add_b_c   = 8'h00;
        add_cin_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    sub_d   = bus.op_sub;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                add_a_c   = a_q[8*idx_q +: 8];
                add_b_c   = sub_q ? ~b_q[8*idx_q +: 8] : b_q[8*idx_q +: 8];
                add_cin_c = carry_q;
                sum_d[8*idx_q +: 8] = bus.add_sum;
                carry_d   = bus.add_cout;
                idx_d     = idx_q + IW'(1);
                if (last_byte) begin
                    // On the MSB byte, add_a[7] is A's sign bit and add_b[7]
                    // is the sign bit of the effective B, so overflow means
                    // the operands share a sign and the result sign differs.
                    cout_d  = bus.add_cout;
                    ovf_d   = (a_q[W-1] == add_b_c[7]) && (bus.add_sum[7] != a_q[W-1]);
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // A start that arrives in this cycle is dropped on purpose.
                // busy is still high, so the requester must retry.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum_out  = sum_q;
    assign bus.cout_out = cout_q;
    assign bus.ovf_out  = ovf_q;
    assign bus.add_a    = add_a_c;
    assign bus.add_b    = add_b_c;
    assign bus.add_cin  = add_cin_c;
endmodule
